// File: rtl/softusb_txpkt.sv
// USB packet transmitter front end: frames SYNC, PID, optional payload and
// optional CRC16 into a byte stream for the bit-level serializer.
module softusb_txpkt (
  input  logic       usb_clk,
  input  logic       usb_rst,

  input  logic       start,
  input  logic [3:0] pid,
  input  logic       payload_en,
  input  logic       crc16_en,

  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,

  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,

  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRCL,
    S_CRCH
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'hA001;

  state_t      state, state_d;
  logic [3:0]  pid_q, pid_d;
  logic        pen_q, pen_d;
  logic        cen_q, cen_d;
  logic        last_q, last_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d;
  logic        done_d;
  logic        underrun_d;

  logic        accept;
  logic        need_byte;

  // Reflected CRC16 update, data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign accept    = tx_valid & tx_ready;
  // A payload byte must be fetched when the byte on the wire is taken and
  // it is either the PID of a payload packet or a non-final payload byte.
  assign need_byte = accept & (((state == S_PID) & pen_q) | ((state == S_DATA) & ~last_q));
  assign pl_ready  = need_byte & pl_valid;
  assign busy      = (state != S_IDLE);

  // Next-state, next-output and payload handshake decode.
  always_comb begin
    state_d    = state;
    pid_d      = pid_q;
    pen_d      = pen_q;
    cen_d      = cen_q;
    last_d     = last_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          pid_d      = pid;
          pen_d      = payload_en;
          cen_d      = crc16_en;
          last_d     = 1'b0;
          crc_d      = CRC_INIT;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          state_d    = S_SYNC;
        end
      end

      S_SYNC: begin
        if (accept) begin
          tx_data_d = {~pid_q, pid_q};
          state_d   = S_PID;
        end
      end

      // PID and DATA share the fetch / CRC / finish decision; need_byte
      // already distinguishes "more payload" from "payload complete".
      S_PID, S_DATA: begin
        if (accept) begin
          if (need_byte) begin
            if (pl_valid) begin
              tx_data_d = pl_data;
              last_d    = pl_last;
              crc_d     = crc16_byte(crc_q, pl_data);
              state_d   = S_DATA;
            end else begin
              tx_data_d  = '0;
              tx_valid_d = 1'b0;
              underrun_d = 1'b1;
              state_d    = S_IDLE;
            end
          end else if (cen_q) begin
            tx_data_d = ~crc_q[7:0];
            state_d   = S_CRCL;
          end else begin
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_CRCL: begin
        if (accept) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = S_CRCH;
        end
      end

      S_CRCH: begin
        if (accept) begin
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State, latched packet parameters, CRC and registered outputs.
  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state    <= S_IDLE;
      pid_q    <= '0;
      pen_q    <= 1'b0;
      cen_q    <= 1'b0;
      last_q   <= 1'b0;
      crc_q    <= CRC_INIT;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_d;
      pid_q    <= pid_d;
      pen_q    <= pen_d;
      cen_q    <= cen_d;
      last_q   <= last_d;
      crc_q    <= crc_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      done     <= done_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_softusb_txpkt.sv
// Bench for softusb_txpkt: directed packets with literal expectations plus
// randomized packets checked against a byte-list model of the packet format.
module tb_softusb_txpkt;

  logic       usb_clk = 1'b0;
  logic       usb_rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pid = '0;
  logic       payload_en = 1'b0;
  logic       crc16_en = 1'b0;
  logic [7:0] pl_data = '0;
  logic       pl_valid = 1'b0;
  logic       pl_last = 1'b0;
  logic       pl_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       underrun;

  softusb_txpkt dut (
    .usb_clk    (usb_clk),
    .usb_rst    (usb_rst),
    .start      (start),
    .pid        (pid),
    .payload_en (payload_en),
    .crc16_en   (crc16_en),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_last    (pl_last),
    .pl_ready   (pl_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 usb_clk = ~usb_clk;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  int und_cnt  = 0;
  int kcyc = 0;
  int ready_mode = 1;
  int consumed = 0;
  int stall_after = -1;

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];

  logic       pl_ready_seen = 1'b0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_rst = 1'b1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of the transmitted stream against the model queue.
  always @(negedge usb_clk) begin
    logic [7:0] e;
    if (!prev_rst && prev_v && !prev_r) begin
      chk("hold_valid", {15'd0, tx_valid}, 16'd1);
      chk("hold_data", {8'd0, tx_data}, {8'd0, prev_d});
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte", {8'd0, tx_data}, 16'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {8'd0, tx_data}, {8'd0, e});
      end
    end
    if (pl_ready === 1'b1)
      chk("pl_ready_qual", {15'd0, pl_valid & tx_valid & tx_ready}, 16'd1);
    if (done === 1'b1 || underrun === 1'b1) begin
      chk("end_tx_valid", {15'd0, tx_valid}, 16'd0);
      chk("end_busy", {15'd0, busy}, 16'd0);
    end
    if (done === 1'b1) done_cnt++;
    if (underrun === 1'b1) und_cnt++;
    pl_ready_seen = pl_ready;
    prev_v   = tx_valid;
    prev_r   = tx_ready;
    prev_d   = tx_data;
    prev_rst = usb_rst;
  end

  // One clock of stimulus: retire a consumed payload byte, drive the next.
  task automatic step();
    @(posedge usb_clk);
    #1;
    kcyc++;
    if (pl_ready_seen) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      consumed++;
    end
    if (src_q.size() > 0 && !(stall_after >= 0 && consumed >= stall_after)) begin
      pl_valid = 1'b1;
      pl_data  = src_q[0];
      pl_last  = (src_q.size() == 1);
    end else begin
      pl_valid = 1'b0;
      pl_data  = 8'($urandom);
      pl_last  = 1'b0;
    end
    case (ready_mode)
      1:       tx_ready = 1'b1;
      2:       tx_ready = (kcyc % 8 == 0);
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Packet model: SYNC, PID with check nibble, payload, complemented CRC16.
  task automatic build_exp(input logic [3:0] p, input logic pen, input logic cen);
    int unsigned crc;
    exp_q.push_back(8'h80);
    exp_q.push_back({~p, p});
    crc = 16'hFFFF;
    if (pen) begin
      foreach (src_q[i]) begin
        exp_q.push_back(src_q[i]);
        crc = crc ^ src_q[i];
        for (int b = 0; b < 8; b++)
          crc = (crc % 2 == 1) ? ((crc / 2) ^ 32'hA001) : (crc / 2);
      end
    end
    if (cen) begin
      exp_q.push_back(8'((crc % 256) ^ 255));
      exp_q.push_back(8'((crc / 256) ^ 255));
    end
  endtask

  task automatic run_pkt(input string name, input logic [3:0] p, input logic pen,
                         input logic cen, input int mode, input int restart_at,
                         input int rst_at, input int want_done, input int want_und);
    int d0;
    int u0;
    int n;
    bit ended;
    d0 = done_cnt;
    u0 = und_cnt;
    n = 0;
    ended = 0;
    ready_mode = mode;
    consumed = 0;
    pid = p;
    payload_en = pen;
    crc16_en = cen;
    start = 1'b1;
    step();
    start = 1'b0;
    pid = 4'($urandom);
    payload_en = 1'($urandom);
    crc16_en = 1'($urandom);
    while (!ended && n < 2000) begin
      if (n == restart_at) begin
        start = 1'b1;
        pid = 4'($urandom);
      end
      if (rst_at >= 0 && consumed >= rst_at) begin
        usb_rst = 1'b1;
        step();
        usb_rst = 1'b0;
        @(negedge usb_clk);
        chk({name, "_rst_tx_valid"}, {15'd0, tx_valid}, 16'd0);
        chk({name, "_rst_busy"}, {15'd0, busy}, 16'd0);
        exp_q.delete();
        src_q.delete();
        ended = 1;
      end else begin
        step();
        start = 1'b0;
        n++;
        if (done_cnt != d0 || und_cnt != u0) ended = 1;
      end
    end
    start = 1'b0;
    if (!ended) chk({name, "_timeout"}, 16'd1, 16'd0);
    for (int i = 0; i < 3; i++) step();
    chk({name, "_done_pulses"}, 16'(done_cnt - d0), 16'(want_done));
    chk({name, "_underrun_pulses"}, 16'(und_cnt - u0), 16'(want_und));
    chk({name, "_bytes_left"}, 16'(exp_q.size()), 16'd0);
    chk({name, "_idle_busy"}, {15'd0, busy}, 16'd0);
    exp_q.delete();
    src_q.delete();
    stall_after = -1;
  endtask

  initial begin
    logic [3:0] rp;
    logic       rpen;
    logic       rcen;
    int         len;

    // Reset asserted together with start: reset must win.
    start = 1'b1;
    pid = 4'h5;
    step();
    step();
    @(negedge usb_clk);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_underrun", {15'd0, underrun}, 16'd0);
    chk("rst_pl_ready", {15'd0, pl_ready}, 16'd0);
    step();
    usb_rst = 1'b0;
    start = 1'b0;
    step();
    step();
    chk("post_rst_busy", {15'd0, busy}, 16'd0);

    // ACK handshake, serializer ready once every 8 cycles.
    exp_q = '{8'h80, 8'hD2};
    run_pkt("ack", 4'h2, 1'b0, 1'b0, 2, -1, -1, 1, 0);

    // Zero-length DATA0 with CRC.
    exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
    run_pkt("data0_zlp", 4'h3, 1'b0, 1'b1, 0, -1, -1, 1, 0);

    // DATA1 "123456789" with CRC16 check value.
    src_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
              8'h38, 8'h39, 8'hC8, 8'hB4};
    run_pkt("data1", 4'hB, 1'b1, 1'b1, 0, -1, -1, 1, 0);

    // IN token with precomputed CRC5 bytes; start re-pulsed mid-packet.
    src_q = '{8'h81, 8'h58};
    exp_q = '{8'h80, 8'h69, 8'h81, 8'h58};
    run_pkt("in_token", 4'h9, 1'b1, 1'b0, 1, 2, -1, 1, 0);

    // Underrun: payload source stalls after the second byte.
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    stall_after = 2;
    exp_q = '{8'h80, 8'h4B, 8'h11, 8'h22};
    run_pkt("underrun", 4'hB, 1'b1, 1'b1, 0, -1, -1, 0, 1);

    // Reset in the middle of DATA, then a clean packet.
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    build_exp(4'h3, 1'b1, 1'b1);
    run_pkt("mid_rst", 4'h3, 1'b1, 1'b1, 0, -1, 3, 0, 0);
    src_q = '{8'h01, 8'h02, 8'h03};
    build_exp(4'hB, 1'b1, 1'b1);
    run_pkt("after_rst", 4'hB, 1'b1, 1'b1, 1, -1, -1, 1, 0);

    // Randomized packets against the model.
    for (int k = 0; k < 30; k++) begin
      rp   = 4'($urandom);
      rpen = 1'($urandom);
      rcen = 1'($urandom);
      len  = $urandom_range(1, 12);
      if (rpen)
        for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      build_exp(rp, rpen, rcen);
      run_pkt("rand", rp, rpen, rcen, $urandom_range(0, 1), -1, -1, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/softusb_txpkt.md
SOFTUSB_TXPKT -- requirements
Module: softusb_txpkt

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: usb_clk in 1 (all logic on rising edge); usb_rst in 1 (synchronous, active-high).
REQ-002 SHALL have the following control ports: start in 1 (begin packet, sampled only when idle); pid in 4 (packet identifier); payload_en in 1 (packet carries payload bytes); crc16_en in 1 (append CRC16).
REQ-003 SHALL have the following payload stream ports: pl_data in 8; pl_valid in 1; pl_last in 1 (marks final payload byte); pl_ready out 1 (byte consumed this cycle).
REQ-004 SHALL have the following serializer-side ports, connected directly to softusb_tx: tx_data out 8; tx_valid out 1; tx_ready in 1 (byte accepted when tx_valid && tx_ready).
REQ-005 SHALL have the following status ports: busy out 1; done out 1 (one-cycle pulse); underrun out 1 (one-cycle pulse).

Function
REQ-006 SHALL implement states IDLE, SYNC, PID, DATA, CRCL, CRCH.
REQ-007 SHALL, on start=1 in IDLE, latch pid, payload_en and crc16_en, enter SYNC, and present tx_data=0x80 with tx_valid=1 on the next cycle; start outside IDLE SHALL be ignored.
REQ-008 SHALL, on SYNC accept, present PID byte {~pid, pid} (e.g. pid 4'h5 -> 0xA5, 4'h3 -> 0xC3).
REQ-009 SHALL, after PID accept, go to DATA if payload_en=1, else CRCL if crc16_en=1, else end the packet.
REQ-010 SHALL, in DATA, load the next payload byte into tx_data when the current byte is accepted; pl_ready SHALL be 1 only in that load cycle, combinationally requiring pl_valid=1.
REQ-011 SHALL, after the byte flagged pl_last is accepted, go to CRCL if crc16_en=1, else end the packet.
REQ-012 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-013 SHALL compute CRC16 over payload bytes only: polynomial x^16+x^15+x^2+1, bits LSB first (reflected 0xA001), init 0xFFFF, updated per byte at pl_ready.
REQ-014 SHALL transmit the complemented CRC16 low byte in CRCL and high byte in CRCH; zero-length CRC packets SHALL send 0x00, 0x00.
REQ-015 SHALL, at packet end (last byte accepted), drive tx_valid=0 for at least one cycle, pulse done for one cycle, and return to IDLE, so that softusb_tx generates EOP.
REQ-016 SHALL, when a payload byte is needed in DATA with pl_valid=0, treat the condition as underrun: drive tx_valid=0 next cycle, pulse underrun, not pulse done, and return to IDLE (packet aborted).
REQ-017 SHALL drive busy=1 in every state except IDLE.
REQ-018 SHALL send payload bytes verbatim with crc16_en=0, so firmware can supply token bytes with a precomputed CRC5.
REQ-019 SHALL have a maximum latency of one cycle from accept of byte N to byte N+1 valid, giving back-to-back transfer when tx_ready is held high.

Reset
REQ-020 SHALL, while usb_rst=1, force IDLE, tx_valid=0, tx_data=0x00, pl_ready=0, busy=0, done=0, underrun=0, and CRC=0xFFFF.
REQ-021 SHALL let usb_rst win over a simultaneous start.
REQ-022 SHALL, on reset mid-packet, abort the packet with no done or underrun pulse.

Verification
REQ-023 SHALL be verified by an ACK bench: pid=2, payload_en=0, crc16_en=0, tx_ready pulsed every 8 cycles -> bytes 0x80, 0xD2, then tx_valid=0 and one done pulse.
REQ-024 SHALL be verified by a zero-length DATA0 bench: pid=3, payload_en=0, crc16_en=1 -> 0x80, 0xC3, 0x00, 0x00.
REQ-025 SHALL be verified by a DATA1 bench: pid=4'hB, payload 0x31..0x39 ("123456789"), crc16_en=1 -> 0x80, 0x4B, 0x31..0x39, 0xC8, 0xB4.
REQ-026 SHALL be verified by an IN token bench: pid=9, payload 0x81, 0x58, crc16_en=0 -> 0x80, 0x69, 0x81, 0x58 verbatim; start reasserted mid-packet is ignored.
REQ-027 SHALL be verified by an underrun bench: pl_valid dropped after the 2nd payload byte -> tx_valid=0, one underrun pulse, busy=0 on the following cycle.
REQ-028 SHALL be verified by a mid-packet reset bench: usb_rst asserted during DATA -> tx_valid=0 and busy=0 next cycle; the next packet is byte-exact.
